// File: rtl/beam_voice_scheduler.sv
// beam_voice_scheduler: debounced laser-harp beams scanned round-robin onto a shared voice pool.
// Optional macro VOICE_STEAL_EN: when all voices are busy, steal the least-recently-assigned voice.
module beam_voice_scheduler #(
    parameter int NUM_BEAMS       = 8,
    parameter int NUM_VOICES      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [NUM_BEAMS-1:0]                   beam_light,
    input  logic                                   pedal,
    output logic [NUM_VOICES-1:0]                  voice_gate,
    output logic [NUM_VOICES*$clog2(NUM_BEAMS)-1:0] voice_beam,
    output logic [NUM_VOICES-1:0]                  voice_start,
    output logic                                   all_busy
);
    localparam int BW = $clog2(NUM_BEAMS);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, ALLOC, STEAL, RELEASE} state_t;

    logic [NUM_BEAMS-1:0] ls1_q, ls2_q;
    logic                 ps1_q, ps2_q;
    state_t               state_q, state_d;
    logic [BW-1:0]        ptr_q, ptr_d;
    logic [NUM_BEAMS-1:0] deb_q, deb_d, play_q, play_d, blk_q, blk_d;
    logic [CW-1:0]        cnt_q [NUM_BEAMS], cnt_d [NUM_BEAMS];
    logic [VW-1:0]        owner_q [NUM_BEAMS], owner_d [NUM_BEAMS];
    logic [NUM_VOICES-1:0] gate_q, gate_d, start_q, start_d;
    logic [BW-1:0]        vbeam_q [NUM_VOICES], vbeam_d [NUM_VOICES];
    logic [VW-1:0]        rank_q [NUM_VOICES], rank_d [NUM_VOICES];
    logic                 busy_q, busy_d;
    logic                 asg_en;
    logic [VW-1:0]        asg_v, free_v;
`ifdef VOICE_STEAL_EN
    logic [VW-1:0]        victim_q, victim_d, vict;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        deb_d   = deb_q;
        play_d  = play_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        gate_d  = gate_q;
        start_d = '0;
        vbeam_d = vbeam_q;
        rank_d  = rank_q;
        busy_d  = &gate_q;
        asg_en  = 1'b0;
        asg_v   = '0;
        free_v  = '0;
`ifdef VOICE_STEAL_EN
        victim_d = victim_q;
        vict     = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (rank_q[v] == VW'(NUM_VOICES - 1)) vict = VW'(v);
`endif
        for (int b = 0; b < NUM_BEAMS; b++) begin
            if (~ls2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[b] = ~deb_q[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end else begin
                cnt_d[b] = '0;
            end
            // A stolen beam stays locked out until it is seen restored.
            if (!deb_q[b]) blk_d[b] = 1'b0;
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--)
            if (!gate_q[v]) free_v = VW'(v);
        case (state_q)
            SCAN: begin
                if (enable) begin
                    if (deb_q[ptr_q] && !play_q[ptr_q] && !blk_q[ptr_q]) state_d = ALLOC;
                    else if (!deb_q[ptr_q] && play_q[ptr_q] && !ps2_q) state_d = RELEASE;
                    else ptr_d = ptr_q + 1'b1;
                end
            end
            ALLOC: begin
                if (!(&gate_q)) begin
                    asg_en = 1'b1;
                    asg_v  = free_v;
                end else begin
`ifdef VOICE_STEAL_EN
                    victim_d              = vict;
                    gate_d[vict]          = 1'b0;
                    play_d[vbeam_q[vict]] = 1'b0;
                    blk_d[vbeam_q[vict]]  = 1'b1;
                    state_d               = STEAL;
`else
                    ptr_d   = ptr_q + 1'b1;
                    state_d = SCAN;
`endif
                end
            end
`ifdef VOICE_STEAL_EN
            STEAL: begin
                asg_en = 1'b1;
                asg_v  = victim_q;
            end
`endif
            RELEASE: begin
                gate_d[owner_q[ptr_q]] = 1'b0;
                play_d[ptr_q]          = 1'b0;
                ptr_d                  = ptr_q + 1'b1;
                state_d                = SCAN;
            end
            default: state_d = SCAN;
        endcase
        if (asg_en) begin
            gate_d[asg_v]  = 1'b1;
            start_d[asg_v] = 1'b1;
            vbeam_d[asg_v] = ptr_q;
            play_d[ptr_q]  = 1'b1;
            owner_d[ptr_q] = asg_v;
            for (int v = 0; v < NUM_VOICES; v++)
                if (rank_q[v] < rank_q[asg_v]) rank_d[v] = rank_q[v] + 1'b1;
            rank_d[asg_v] = '0;
            ptr_d         = ptr_q + 1'b1;
            state_d       = SCAN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ls1_q   <= '1;
            ls2_q   <= '1;
            ps1_q   <= 1'b0;
            ps2_q   <= 1'b0;
            state_q <= SCAN;
            ptr_q   <= '0;
            deb_q   <= '0;
            play_q  <= '0;
            blk_q   <= '0;
            gate_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            for (int b = 0; b < NUM_BEAMS; b++) begin
                cnt_q[b]   <= '0;
                owner_q[b] <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                vbeam_q[v] <= '0;
                rank_q[v]  <= VW'(v);
            end
`ifdef VOICE_STEAL_EN
            victim_q <= '0;
`endif
        end else begin
            ls1_q   <= beam_light;
            ls2_q   <= ls1_q;
            ps1_q   <= pedal;
            ps2_q   <= ps1_q;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            deb_q   <= deb_d;
            play_q  <= play_d;
            blk_q   <= blk_d;
            gate_q  <= gate_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            vbeam_q <= vbeam_d;
            rank_q  <= rank_d;
`ifdef VOICE_STEAL_EN
            victim_q <= victim_d;
`endif
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_vb
        assign voice_beam[v*BW +: BW] = vbeam_q[v];
    end

    assign voice_gate  = gate_q;
    assign voice_start = start_q;
    assign all_busy    = busy_q;
endmodule

// File: tb/tb_beam_voice_scheduler.sv
// tb_beam_voice_scheduler: directed checks of allocation, release, debounce, steal/no-steal, pedal, enable and reset.
module tb_beam_voice_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  beam_light = 8'hFF;
    logic        pedal = 1'b0;
    logic [3:0]  voice_gate;
    logic [11:0] voice_beam;
    logic [3:0]  voice_start;
    logic        all_busy;
    int          total = 0;
    int          bad = 0;
    int          starts [4] = '{0, 0, 0, 0};
    int          s0;

    beam_voice_scheduler #(.NUM_BEAMS(8), .NUM_VOICES(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .beam_light(beam_light), .pedal(pedal),
        .voice_gate(voice_gate), .voice_beam(voice_beam), .voice_start(voice_start), .all_busy(all_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        for (int v = 0; v < 4; v++) starts[v] += int'(voice_start[v]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gate(input logic [3:0] mask, input logic [3:0] val, input int bound, input string tag);
        for (int i = 0; i < bound && (voice_gate & mask) != val; i++) @(negedge clk);
        chk(tag, 32'(voice_gate & mask), 32'(val));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_gate", 32'(voice_gate), 0);
        chk("rst_start", 32'(voice_start), 0);
        chk("rst_beam", 32'(voice_beam), 0);
        chk("rst_busy", 32'(all_busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        beam_light = 8'hF7;
        wait_gate(4'hF, 4'h1, 16, "alloc3_gate");
        chk("alloc3_beam", 32'(voice_beam[2:0]), 3);
        chk("alloc3_start", 32'(starts[0]), 1);
        beam_light = 8'hFF;
        wait_gate(4'hF, 4'h0, 16, "rel3_gate");
        s0 = starts[0] + starts[1] + starts[2] + starts[3];
        beam_light = 8'hDF;
        repeat (3) @(negedge clk);
        beam_light = 8'hFF;
        repeat (20) @(negedge clk);
        chk("glitch_start", 32'(starts[0] + starts[1] + starts[2] + starts[3]), 32'(s0));
        chk("glitch_gate", 32'(voice_gate), 0);

        enable = 1'b0;
        do_reset();
        beam_light = 8'hF0;
        repeat (12) @(negedge clk);
        chk("en0_gate", 32'(voice_gate), 0);
        enable = 1'b1;
        wait_gate(4'hF, 4'hF, 20, "fill_gate");
        chk("fill_beams", 32'(voice_beam), 32'h688);
        @(negedge clk);
        chk("fill_busy", 32'(all_busy), 1);
`ifdef VOICE_STEAL_EN
        beam_light = 8'hB0;
        for (int i = 0; i < 30 && voice_gate[0]; i++) @(negedge clk);
        chk("steal_gap", 32'(voice_gate), 32'hE);
        @(negedge clk);
        chk("steal_regate", 32'(voice_gate), 32'hF);
        chk("steal_start", 32'(voice_start), 32'h1);
        chk("steal_beam", 32'(voice_beam[2:0]), 6);
        beam_light = 8'h90;
        for (int i = 0; i < 30 && voice_gate[1]; i++) @(negedge clk);
        chk("steal2_gap", 32'(voice_gate), 32'hD);
        reset_n = 1'b0;
        #1;
        chk("gaprst_gate", 32'(voice_gate), 0);
        chk("gaprst_beam", 32'(voice_beam), 0);
        chk("gaprst_start", 32'(voice_start), 0);
        chk("gaprst_busy", 32'(all_busy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 30 && voice_gate == 4'h0; i++) @(negedge clk);
        chk("gaprst_first", 32'(voice_gate), 32'h1);
        wait_gate(4'hF, 4'hF, 40, "gaprst_fill");
`else
        s0 = starts[0] + starts[1] + starts[2] + starts[3];
        beam_light = 8'hB0;
        repeat (25) @(negedge clk);
        chk("nosteal_gate", 32'(voice_gate), 32'hF);
        chk("nosteal_beams", 32'(voice_beam), 32'h688);
        chk("nosteal_start", 32'(starts[0] + starts[1] + starts[2] + starts[3]), 32'(s0));
        beam_light = 8'hB4;
        wait_gate(4'h4, 4'h0, 30, "nosteal_rel2");
        chk("nosteal_rel2_all", 32'(voice_gate), 32'hB);
        wait_gate(4'h4, 4'h4, 30, "nosteal_re2");
        chk("nosteal_re2_beam", 32'(voice_beam[8:6]), 6);
        reset_n = 1'b0;
        #1;
        chk("midrst_gate", 32'(voice_gate), 0);
        chk("midrst_beam", 32'(voice_beam), 0);
        chk("midrst_busy", 32'(all_busy), 0);
`endif
        beam_light = 8'hFF;
        do_reset();
        pedal = 1'b1;
        repeat (3) @(negedge clk);
        beam_light = 8'hEF;
        wait_gate(4'hF, 4'h1, 20, "pedal_alloc");
        beam_light = 8'hFF;
        repeat (30) @(negedge clk);
        chk("pedal_hold", 32'(voice_gate), 32'h1);
        pedal = 1'b0;
        wait_gate(4'hF, 4'h0, 14, "pedal_rel");

        enable = 1'b0;
        beam_light = 8'h7F;
        repeat (20) @(negedge clk);
        chk("en0_hold", 32'(voice_gate), 0);
        enable = 1'b1;
        wait_gate(4'hF, 4'h1, 10, "en1_alloc");
        chk("en1_beam", 32'(voice_beam[2:0]), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/beam_voice_scheduler.md
Name: beam_voice_scheduler

Overview:
- Shares a fixed pool of synth voices among the laser-harp beams.
- Synchronises and debounces the photodiode beam inputs and scans beams round-robin.
- Assigns a voice to each newly broken beam and releases voices when beams are restored, with sustain-pedal hold.
- Sits between the photodiode/pedal conduits and the audio voice generators feeding the audio core.

Parameters:
- NUM_BEAMS, 8, number of beam inputs (power of 2, 2..16).
- NUM_VOICES, 4, number of shared synth voices (2..8).
- DEBOUNCE_CYCLES, 50000, stable cycles needed before a beam state change is accepted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, scanning halts; existing voices are held.
- beam_light  in  NUM_BEAMS  raw photodiode levels; 1 = light received, 0 = beam broken. Asynchronous.
- pedal  in  1  sustain pedal, active-high, asynchronous.
- voice_gate  out  NUM_VOICES  per-voice note gate.
- voice_beam  out  NUM_VOICES*log2(NUM_BEAMS)  beam index per voice; voice v occupies slice v.
- voice_start  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.
- all_busy  out  1  all voices gated.

Behaviour:
- Reset is asynchronous and active-low, with a single clock domain (clk). Reset applies at any time, including mid-scan or mid-steal:
  - voice_gate=0, voice_start=0, voice_beam=0, all_busy=0.
  - Scan pointer=0; FSM=SCAN.
  - All debounced beams=restored (not broken); no beam marked playing.
  - LRU rank of voice v = v.
- Input conditioning:
  - Two-flop synchroniser on every beam_light bit and on pedal.
  - Per-beam counter, width ceil(log2(DEBOUNCE_CYCLES+1)). It counts while the synced level differs from the debounced state and clears on any match.
  - At DEBOUNCE_CYCLES the debounced state flips and the counter clears.
  - Pedal is synchronised only, not debounced.
- Per-beam state: playing bit and owning voice index.
- FSM states: SCAN, ALLOC, STEAL, RELEASE. When enable=0, the FSM stays in SCAN and the pointer is held.
- SCAN, one beam per cycle at the pointer:
  - If broken and not playing: go to ALLOC.
  - Else if restored, playing and synced pedal=0: go to RELEASE.
  - Else: pointer+1, wrapping from NUM_BEAMS-1 to 0.
- ALLOC:
  - If any voice has gate=0, take the lowest-index free voice: gate=1, voice_beam=pointer, voice_start pulse, beam marked playing, LRU update, pointer+1, back to SCAN.
  - If all voices are busy, behaviour depends on VOICE_STEAL_EN.
- STEAL:
  - Victim = voice with the highest LRU rank.
  - Victim gate=0 for exactly one cycle; its old beam's playing bit is cleared.
  - Next cycle: assign as in ALLOC (gate=1, start pulse, voice_beam=new beam).
- RELEASE: owning voice gate=0, beam playing cleared, pointer+1, back to SCAN. Ranks are unchanged.
- LRU update on assignment of voice k with old rank r: rank[k]=0; every voice with rank<r increments. Ranks stay a permutation of 0..NUM_VOICES-1.
- Pedal:
  - While synced pedal=1, releases are deferred and gates stay high.
  - On pedal falling, held voices whose beams are restored release as the scan reaches them, within NUM_BEAMS+2 cycles.
- all_busy = AND of voice_gate, registered.
- Latency:
  - Debounced change to voice_start is at most NUM_BEAMS+2 cycles, or NUM_BEAMS+3 with a steal.
  - Raw input to debounced state is 2+DEBOUNCE_CYCLES cycles.
- Simultaneous events:
  - Beams are served strictly in pointer order, one event per visit.
  - A beam that breaks and restores within DEBOUNCE_CYCLES never produces an event.
  - A broken beam whose voice was stolen is not re-allocated until it is restored and broken again.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: ALLOC with all voices busy goes to STEAL, which steals the least-recently-assigned voice.
- Undefined:
  - The STEAL state is absent; ALLOC with all voices busy returns to SCAN with pointer+1 and no output change.
  - The beam stays unplayed and is retried on each later visit, so it gets a voice once one frees while the beam is still broken.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BEAMS=8, NUM_VOICES=4):
- Reset, then break beam 3 and hold → after 6 cycles debounced; within 10 cycles voice_gate=0001, voice_beam[0]=3, one voice_start[0] pulse. Restore beam 3 → voice_gate=0000 within 16 cycles.
- Glitch beam 5 low for 3 cycles → no voice_start, voice_gate stays 0000.
- Break beams 0,1,2,3 → voices 0..3 gated, all_busy=1. Then break beam 6:
  - With VOICE_STEAL_EN: voice 0 gate low for exactly 1 cycle, then voice_beam[0]=6 with voice_start[0] pulse.
  - Without VOICE_STEAL_EN: no change; restore beam 2 → voice 2 freed, then voice 2 reassigned to beam 6.
- pedal=1, break then restore beam 4 → gate stays high. Drop pedal → gate falls within 12 cycles.
- Assert reset_n low during the one-cycle STEAL gap → all outputs 0 immediately. After release, with beams held broken, voices are reallocated from voice 0 upward.
- enable=0 while breaking beam 7 → no allocation. Set enable=1 → allocation within 10 cycles.
